// File: rtl/wb_mem_arbiter_if.sv
// Wishbone classic bus bundle shared by the arbiter's two master-side ports and its memory-side port.
// Modports are named from the arbiter's point of view on that bus.
interface wb_mem_arbiter_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [3:0]  sel;
   logic [31:0] adr;
   logic [31:0] dat_w;
   logic [31:0] dat_r;
   logic        ack;
   logic        err;

   // mem_wb has no error line, so the memory-side view omits err
   modport master (output cyc, stb, we, sel, adr, dat_w, input ack, dat_r);
   modport slave  (input cyc, stb, we, sel, adr, dat_w, output ack, err, dat_r);
endinterface

// File: rtl/wb_mem_arbiter.sv
// Two-master round-robin Wishbone arbiter in front of the mem_wb SRAM port.
// Ownership spans a whole cyc; a per-strobe watchdog turns a missing ack into err.
module wb_mem_arbiter #(
   parameter int TIMEOUT = 15,
   parameter bit PRIO_M0 = 1'b0
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_ni,
   wb_mem_arbiter_if.slave  m0,
   wb_mem_arbiter_if.slave  m1,
   wb_mem_arbiter_if.master s,
   output logic [1:0]       gnt_o
);

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

   state_t     r_state, w_state_nxt;
   logic       r_last;
   logic [7:0] r_wd;
   logic       r_tmo;

   logic w_req0, w_req1, w_owned, w_owner_stb, w_hit, w_block;

   assign w_req0      = m0.cyc & m0.stb;
   assign w_req1      = m1.cyc & m1.stb;
   assign w_owned     = (r_state == OWN0) | (r_state == OWN1);
   assign w_owner_stb = (r_state == OWN0) ? m0.stb : (r_state == OWN1) ? m1.stb : 1'b0;
   // The expiry cycle itself already blocks the slave so stb drops together with err
   assign w_hit       = w_owned & ~r_tmo & (r_wd == 8'(TIMEOUT));
   assign w_block     = r_tmo | w_hit;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_req0 & w_req1)
               w_state_nxt = (PRIO_M0 || r_last) ? OWN0 : OWN1;
            else if (w_req0)
               w_state_nxt = OWN0;
            else if (w_req1)
               w_state_nxt = OWN1;
         end
         OWN0:    if (!m0.cyc) w_state_nxt = IDLE;
         OWN1:    if (!m1.cyc) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_state <= IDLE;
         r_last  <= 1'b1;
      end else begin
         r_state <= w_state_nxt;
         if (r_state == IDLE && w_state_nxt == OWN0) r_last <= 1'b0;
         if (r_state == IDLE && w_state_nxt == OWN1) r_last <= 1'b1;
      end
   end

   // tmo holds until the owner gives up the cycle; it is also wiped in IDLE
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         r_wd  <= 8'd0;
         r_tmo <= 1'b0;
      end else if (w_hit) begin
         r_wd  <= 8'd0;
         r_tmo <= 1'b1;
      end else begin
         if (r_state == IDLE || s.ack || !w_owner_stb)
            r_wd <= 8'd0;
         else if (s.stb)
            r_wd <= r_wd + 8'd1;
         if (r_state == IDLE || w_state_nxt == IDLE)
            r_tmo <= 1'b0;
      end
   end

   always_comb begin
      s.cyc    = 1'b0;
      s.stb    = 1'b0;
      s.we     = 1'b0;
      s.sel    = 4'd0;
      s.adr    = 32'd0;
      s.dat_w  = 32'd0;
      m0.ack   = 1'b0;
      m0.err   = 1'b0;
      m0.dat_r = 32'd0;
      m1.ack   = 1'b0;
      m1.err   = 1'b0;
      m1.dat_r = 32'd0;
      gnt_o    = 2'b00;
      case (r_state)
         OWN0: begin
            s.cyc    = m0.cyc & ~w_block;
            s.stb    = m0.stb & ~w_block;
            s.we     = m0.we;
            s.sel    = m0.sel;
            s.adr    = m0.adr;
            s.dat_w  = m0.dat_w;
            m0.ack   = s.ack & ~w_block;
            m0.err   = w_hit;
            m0.dat_r = s.dat_r;
            gnt_o    = 2'b01;
         end
         OWN1: begin
            s.cyc    = m1.cyc & ~w_block;
            s.stb    = m1.stb & ~w_block;
            s.we     = m1.we;
            s.sel    = m1.sel;
            s.adr    = m1.adr;
            s.dat_w  = m1.dat_w;
            m1.ack   = s.ack & ~w_block;
            m1.err   = w_hit;
            m1.dat_r = s.dat_r;
            gnt_o    = 2'b10;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Bench for wb_mem_arbiter: table of single transfers plus hand-built contention, hold,
// timeout and reset sequences; a second instance covers the fixed-priority option.
module tb_wb_mem_arbiter;

   logic wb_clk_i = 1'b0;
   logic rst_n;
   always #5 wb_clk_i = ~wb_clk_i;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc_cnt = 0;
   always @(posedge wb_clk_i) cyc_cnt <= cyc_cnt + 1;

   // ---------------- main instance (round robin) ----------------
   wb_mem_arbiter_if m0_bus();
   wb_mem_arbiter_if m1_bus();
   wb_mem_arbiter_if s_bus();
   logic [1:0] gnt;

   wb_mem_arbiter #(.TIMEOUT(15), .PRIO_M0(1'b0)) dut (
      .wb_clk_i (wb_clk_i),
      .wb_rst_ni(rst_n),
      .m0       (m0_bus),
      .m1       (m1_bus),
      .s        (s_bus),
      .gnt_o    (gnt)
   );

   logic        cyc_d[2], stb_d[2], we_d[2];
   logic [3:0]  sel_d[2];
   logic [31:0] adr_d[2], dat_d[2];
   logic        ack_w[2], err_w[2];
   logic [31:0] rd_w[2];

   assign m0_bus.cyc = cyc_d[0]; assign m0_bus.stb = stb_d[0]; assign m0_bus.we = we_d[0];
   assign m0_bus.sel = sel_d[0]; assign m0_bus.adr = adr_d[0]; assign m0_bus.dat_w = dat_d[0];
   assign m1_bus.cyc = cyc_d[1]; assign m1_bus.stb = stb_d[1]; assign m1_bus.we = we_d[1];
   assign m1_bus.sel = sel_d[1]; assign m1_bus.adr = adr_d[1]; assign m1_bus.dat_w = dat_d[1];
   assign ack_w[0] = m0_bus.ack; assign err_w[0] = m0_bus.err; assign rd_w[0] = m0_bus.dat_r;
   assign ack_w[1] = m1_bus.ack; assign err_w[1] = m1_bus.err; assign rd_w[1] = m1_bus.dat_r;

   // mem_wb stand-in: write ack one cycle after stb, read ack two cycles after stb
   logic        mack, rd_pend, noack, force_ack;
   logic [31:0] mdat;
   logic [31:0] mem [64];
   always @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) begin
         mack    <= 1'b0;
         rd_pend <= 1'b0;
         mdat    <= 32'd0;
      end else begin
         mack <= 1'b0;
         if (s_bus.cyc && s_bus.stb && !mack && !noack) begin
            if (s_bus.we) begin
               for (int b = 0; b < 4; b++)
                  if (s_bus.sel[b]) mem[s_bus.adr[7:2]][8*b +: 8] <= s_bus.dat_w[8*b +: 8];
               mack <= 1'b1;
            end else if (rd_pend) begin
               mack    <= 1'b1;
               mdat    <= mem[s_bus.adr[7:2]];
               rd_pend <= 1'b0;
            end else begin
               rd_pend <= 1'b1;
            end
         end else begin
            rd_pend <= 1'b0;
         end
      end
   end
   assign s_bus.ack   = mack | force_ack;
   assign s_bus.dat_r = mdat;
   assign s_bus.err   = 1'b0;

   // ---------------- second instance (fixed priority) ----------------
   wb_mem_arbiter_if pm0();
   wb_mem_arbiter_if pm1();
   wb_mem_arbiter_if ps();
   logic [1:0] pgnt, pcyc;
   logic       pack;

   wb_mem_arbiter #(.TIMEOUT(15), .PRIO_M0(1'b1)) dut_prio (
      .wb_clk_i (wb_clk_i),
      .wb_rst_ni(rst_n),
      .m0       (pm0),
      .m1       (pm1),
      .s        (ps),
      .gnt_o    (pgnt)
   );

   assign pm0.cyc = pcyc[0]; assign pm0.stb = pcyc[0]; assign pm0.we = 1'b1;
   assign pm0.sel = 4'hF;    assign pm0.adr = 32'h0;   assign pm0.dat_w = 32'h0;
   assign pm1.cyc = pcyc[1]; assign pm1.stb = pcyc[1]; assign pm1.we = 1'b1;
   assign pm1.sel = 4'hF;    assign pm1.adr = 32'h4;   assign pm1.dat_w = 32'h0;
   always @(posedge wb_clk_i or negedge rst_n) begin
      if (!rst_n) pack <= 1'b0;
      else        pack <= ps.cyc & ps.stb & !pack;
   end
   assign ps.ack   = pack;
   assign ps.dat_r = 32'h0;
   assign ps.err   = 1'b0;

   // ---------------- checking helpers ----------------
   typedef struct {
      bit          we;
      bit          exp_err;
      logic [31:0] data;
   } sb_t;
   sb_t q0[$];
   sb_t q1[$];
   logic [31:0] ref_mem [64];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [31:0] smask(input logic [3:0] sl);
      return {{8{sl[3]}}, {8{sl[2]}}, {8{sl[1]}}, {8{sl[0]}}};
   endfunction

   // Responses are scored against the per-master queue and the current owner
   logic [1:0] gq[$];
   bit         log_en = 1'b0;
   bit         watch_m0 = 1'b0;
   int         m0_gnt_cyc = -1;
   always @(negedge wb_clk_i) begin
      sb_t e;
      if (rst_n === 1'b1) begin
         for (int i = 0; i < 2; i++) begin
            if (ack_w[i] || err_w[i]) begin
               chk($sformatf("owner_m%0d", i), {30'd0, gnt}, (i == 0) ? 32'd1 : 32'd2);
               if ((i == 0 && q0.size() == 0) || (i == 1 && q1.size() == 0)) begin
                  n_tests++;
                  n_fail++;
                  $display("FAIL sb_unexpected m%0d: response seen, none expected", i);
               end else begin
                  if (i == 0) e = q0.pop_front();
                  else        e = q1.pop_front();
                  chk($sformatf("sb_kind_m%0d", i), {31'd0, err_w[i]}, {31'd0, e.exp_err});
                  if (ack_w[i] && !e.we) chk($sformatf("sb_rdata_m%0d", i), rd_w[i], e.data);
                  if (err_w[i]) chk("stb_low_on_err", {31'd0, s_bus.stb}, 32'd0);
               end
            end
         end
         if (log_en && (gq.size() != 0 || gnt != 2'b00) && (gq.size() == 0 || gq[$] != gnt))
            gq.push_back(gnt);
         if (watch_m0 && gnt == 2'b01 && m0_gnt_cyc < 0) m0_gnt_cyc <= cyc_cnt;
      end
   end

   task automatic xfer(input int i, input bit we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input bit hold, input bit exp_err,
                       output int lat, output int slat, output logic [31:0] rdat);
      sb_t e;
      e.we = we;
      e.exp_err = exp_err;
      e.data = ref_mem[adr[7:2]];
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
      cyc_d[i] = 1'b1; stb_d[i] = 1'b1; we_d[i] = we;
      adr_d[i] = adr;  dat_d[i] = dat;  sel_d[i] = sel;
      lat = -1; slat = -1; rdat = 32'd0;
      for (int n = 0; n < 60; n++) begin
         @(negedge wb_clk_i);
         if (slat < 0 && s_bus.stb) slat = n;
         if (ack_w[i] || err_w[i]) begin
            lat  = n;
            rdat = rd_w[i];
            if (we && ack_w[i])
               ref_mem[adr[7:2]] = (ref_mem[adr[7:2]] & ~smask(sel)) | (dat & smask(sel));
            break;
         end
      end
      if (lat < 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL xfer_wait m%0d adr %h: no ack/err within 60 cycles", i, adr);
      end
      @(posedge wb_clk_i); #1;
      stb_d[i] = 1'b0;
      if (!hold) cyc_d[i] = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge wb_clk_i);
      #1;
   endtask

   typedef struct {
      int          m;
      bit          we;
      logic [31:0] adr;
      logic [31:0] dat;
      logic [3:0]  sel;
      int          lat;
   } vec_t;
   vec_t tbl[7];

   int          lat0, slat0, lat1, slat1, drop_cyc, a0, g1;
   logic [31:0] rd0, rd1;
   logic [1:0]  gexp[5];
   logic        pa0, pa1;

   initial begin
      #100000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      tbl[0] = '{0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 2};
      tbl[1] = '{0, 1'b0, 32'h10, 32'hDEADBEEF, 4'hF, 3};
      tbl[2] = '{1, 1'b1, 32'h20, 32'h12345678, 4'hF, 2};
      tbl[3] = '{1, 1'b0, 32'h20, 32'h12345678, 4'hF, 3};
      tbl[4] = '{0, 1'b0, 32'h20, 32'h12345678, 4'hF, 3};
      tbl[5] = '{1, 1'b1, 32'h10, 32'h0000A5A5, 4'h3, 2};
      tbl[6] = '{0, 1'b0, 32'h10, 32'hDEADA5A5, 4'hF, 3};
      gexp[0] = 2'b01; gexp[1] = 2'b00; gexp[2] = 2'b10; gexp[3] = 2'b00; gexp[4] = 2'b01;
      for (int k = 0; k < 64; k++) ref_mem[k] = 32'd0;

      // reset state, with master 0 actively driving a request
      rst_n = 1'b0; noack = 1'b0; force_ack = 1'b0; pcyc = 2'b00;
      for (int i = 0; i < 2; i++) begin
         cyc_d[i] = 1'b0; stb_d[i] = 1'b0; we_d[i] = 1'b0;
         sel_d[i] = 4'h0; adr_d[i] = 32'h0; dat_d[i] = 32'h0;
      end
      cyc_d[0] = 1'b1; stb_d[0] = 1'b1; we_d[0] = 1'b1;
      sel_d[0] = 4'hF; adr_d[0] = 32'h55; dat_d[0] = 32'h77;
      repeat (3) @(negedge wb_clk_i);
      chk("rst_s_cyc", {31'd0, s_bus.cyc}, 32'd0);
      chk("rst_s_stb", {31'd0, s_bus.stb}, 32'd0);
      chk("rst_s_we",  {31'd0, s_bus.we},  32'd0);
      chk("rst_s_sel", {28'd0, s_bus.sel}, 32'd0);
      chk("rst_s_adr", s_bus.adr, 32'd0);
      chk("rst_s_dat", s_bus.dat_w, 32'd0);
      chk("rst_gnt",   {30'd0, gnt}, 32'd0);
      chk("rst_m0_ack", {31'd0, ack_w[0]}, 32'd0);
      chk("rst_m0_err", {31'd0, err_w[0]}, 32'd0);
      chk("rst_m0_dat", rd_w[0], 32'd0);
      chk("rst_m1_ack", {31'd0, ack_w[1]}, 32'd0);
      cyc_d[0] = 1'b0; stb_d[0] = 1'b0;
      @(negedge wb_clk_i);
      rst_n = 1'b1;
      @(negedge wb_clk_i);
      chk("idle_s_adr", s_bus.adr, 32'd0);
      chk("idle_s_we",  {31'd0, s_bus.we}, 32'd0);
      chk("idle_gnt",   {30'd0, gnt}, 32'd0);
      idle(1);

      // single transfers from IDLE
      for (int k = 0; k < 7; k++) begin
         xfer(tbl[k].m, tbl[k].we, tbl[k].adr, tbl[k].dat, tbl[k].sel, 1'b0, 1'b0, lat0, slat0, rd0);
         chk($sformatf("tbl%0d_ack_lat", k), lat0, tbl[k].lat);
         chk($sformatf("tbl%0d_stb_lat", k), slat0, 32'd1);
         if (!tbl[k].we) chk($sformatf("tbl%0d_rdata", k), rd0, tbl[k].dat);
         idle(2);
      end

      // slave never acks: err after TIMEOUT cycles, then late ack is swallowed
      noack = 1'b1;
      xfer(0, 1'b1, 32'h30, 32'h0BADF00D, 4'hF, 1'b1, 1'b1, lat0, slat0, rd0);
      chk("tmo_err_lat", lat0, 32'd16);
      for (int k = 0; k < 4; k++) begin
         force_ack = (k == 1);
         @(negedge wb_clk_i);
         chk($sformatf("tmo_no_ack%0d", k), {31'd0, ack_w[0]}, 32'd0);
         chk($sformatf("tmo_single_err%0d", k), {31'd0, err_w[0]}, 32'd0);
         @(posedge wb_clk_i); #1;
      end
      force_ack = 1'b0;
      cyc_d[0] = 1'b0;
      noack = 1'b0;
      idle(2);

      // M1 holds cyc over four reads while M0 waits
      watch_m0 = 1'b1;
      m0_gnt_cyc = -1;
      fork
         begin
            xfer(1, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 1'b0, lat1, slat1, rd1);
            chk("b2b_rd0_lat", lat1, 32'd3);
            for (int k = 1; k < 4; k++) begin
               xfer(1, 1'b0, (k % 2 == 1) ? 32'h20 : 32'h10, 32'h0, 4'hF, k < 3, 1'b0, lat1, slat1, rd1);
               chk($sformatf("b2b_rd%0d_lat", k), lat1, 32'd2);
            end
            drop_cyc = cyc_cnt;
         end
         begin
            idle(2);
            xfer(0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF, 1'b0, 1'b0, lat0, slat0, rd0);
         end
      join
      watch_m0 = 1'b0;
      chk("m0_gnt_after_release", m0_gnt_cyc, drop_cyc + 2);
      idle(2);

      // reset during an M1 read, one cycle after grant
      cyc_d[1] = 1'b1; stb_d[1] = 1'b1; we_d[1] = 1'b0; adr_d[1] = 32'h20; sel_d[1] = 4'hF;
      @(posedge wb_clk_i);
      @(negedge wb_clk_i);
      chk("mid_rst_granted", {30'd0, gnt}, 32'd2);
      @(posedge wb_clk_i); #3;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_s_cyc", {31'd0, s_bus.cyc}, 32'd0);
      chk("mid_rst_s_stb", {31'd0, s_bus.stb}, 32'd0);
      chk("mid_rst_gnt",   {30'd0, gnt}, 32'd0);
      cyc_d[1] = 1'b0; stb_d[1] = 1'b0;
      @(negedge wb_clk_i);
      rst_n = 1'b1;
      idle(1);

      // contention straight out of reset: M0, M1, M0
      log_en = 1'b1;
      fork
         begin
            xfer(0, 1'b1, 32'h50, 32'h11111111, 4'hF, 1'b0, 1'b0, lat0, slat0, rd0);
            idle(1);
            xfer(0, 1'b1, 32'h54, 32'h22222222, 4'hF, 1'b0, 1'b0, lat0, slat0, rd0);
         end
         begin
            xfer(1, 1'b1, 32'h58, 32'h33333333, 4'hF, 1'b0, 1'b0, lat1, slat1, rd1);
         end
      join
      log_en = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (k < gq.size()) chk($sformatf("rr_gnt_seq%0d", k), {30'd0, gq[k]}, {30'd0, gexp[k]});
         else begin
            n_tests++;
            n_fail++;
            $display("FAIL rr_gnt_seq%0d: sequence ended early, expected %b", k, gexp[k]);
         end
      end
      idle(2);

      // fixed priority: M0 re-requests right after every transfer and always wins
      a0 = 0; g1 = 0; pa0 = 1'b0; pa1 = 1'b0;
      pcyc = 2'b11;
      for (int k = 0; k < 40; k++) begin
         @(negedge wb_clk_i);
         pa0 = pm0.ack; pa1 = pm1.ack;
         if (pgnt == 2'b10) g1++;
         if (pa0) a0++;
         @(posedge wb_clk_i); #1;
         pcyc[0] = !pa0;
         pcyc[1] = !pa1;
      end
      chk("prio_m1_never_granted", g1, 32'd0);
      chk("prio_m0_served", {31'd0, a0 >= 8}, 32'd1);
      pcyc[0] = 1'b0;
      g1 = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge wb_clk_i);
         if (pgnt == 2'b10) g1++;
      end
      chk("prio_m1_when_m0_idle", {31'd0, g1 > 0}, 32'd1);
      pcyc = 2'b00;
      idle(2);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
